// File: rtl/ascii_hex_parser_if.sv
// Character stream in, parsed hex value and status out.
interface ascii_hex_parser_if #(
    parameter int unsigned NumDigits = 2
) ();
    localparam int unsigned NumBits = 4 * NumDigits;

    logic               clear;
    logic               char_valid;
    logic [7:0]         char;
    logic [NumBits-1:0] value;
    logic               value_valid;
    logic               error;
    logic               busy;

    // Character source side
    modport master (
        output clear,
        output char_valid,
        output char,
        input  value,
        input  value_valid,
        input  error,
        input  busy
    );

    // Parser side
    modport slave (
        input  clear,
        input  char_valid,
        input  char,
        output value,
        output value_valid,
        output error,
        output busy
    );
endinterface

// File: rtl/ascii_hex_parser.sv
// ASCII hex characters in, one per clock, MSD first; NumDigits-nibble value out
// with a one-cycle completion strobe and a one-cycle error strobe on non-hex input.
module ascii_hex_parser #(
    parameter int unsigned NumDigits = 2
) (
    input  logic                clk,
    input  logic                reset,
    ascii_hex_parser_if.slave   bus
);
    localparam int unsigned NumBits = 4 * NumDigits;
    localparam int unsigned CntW    = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NumBits-1:0] acc_q, acc_d;
    logic [NumBits-1:0] value_q, value_d;
    logic               value_valid_q, value_valid_d;
    logic               error_q, error_d;

    logic               hex_ok_c;
    logic [3:0]         nibble_c;
    logic [NumBits-1:0] acc_shift_c;

    // Hex character decode
    always_comb begin
        hex_ok_c = 1'b0;
        nibble_c = 4'h0;
        if (bus.char >= 8'h30 && bus.char <= 8'h39) begin
            hex_ok_c = 1'b1;
            nibble_c = bus.char[3:0];
        end else if ((bus.char >= 8'h41 && bus.char <= 8'h46) ||
                     (bus.char >= 8'h61 && bus.char <= 8'h66)) begin
            hex_ok_c = 1'b1;
            nibble_c = bus.char[3:0] + 4'd9;
        end
    end

    // Shift the new nibble in at the bottom; the cast drops the oldest nibble
    // and degenerates to just the nibble when NumDigits is 1.
    assign acc_shift_c = NumBits'({acc_q, nibble_c});

    // Next-state and datapath update, in priority order clear > invalid > digit
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        error_d       = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (bus.char_valid) begin
            if (!hex_ok_c) begin
                error_d = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end else if (cnt_q == LastCnt) begin
                value_d       = acc_shift_c;
                value_valid_d = 1'b1;
                state_d       = IDLE;
                cnt_d         = '0;
                acc_d         = '0;
            end else begin
                acc_d   = acc_shift_c;
                cnt_d   = cnt_q + CntW'(1);
                state_d = ACCUM;
            end
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            error_q       <= error_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.error       = error_q;
    assign bus.busy        = (state_q == ACCUM);
endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser at NumDigits = 2, 4 and 1.
module tb_ascii_hex_parser;
    logic clk = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    ascii_hex_parser_if #(.NumDigits(2)) i2 ();
    ascii_hex_parser_if #(.NumDigits(4)) i4 ();
    ascii_hex_parser_if #(.NumDigits(1)) i1 ();

    ascii_hex_parser #(.NumDigits(2)) dut2 (.clk(clk), .reset(reset), .bus(i2));
    ascii_hex_parser #(.NumDigits(4)) dut4 (.clk(clk), .reset(reset), .bus(i4));
    ascii_hex_parser #(.NumDigits(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [7:0] c);
        i2.char_valid = 1'b1;
        i2.char       = c;
        step();
        i2.char_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] c);
        i4.char_valid = 1'b1;
        i4.char       = c;
        step();
        i4.char_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] c);
        i1.char_valid = 1'b1;
        i1.char       = c;
        step();
        i1.char_valid = 1'b0;
    endtask

    logic [7:0] bad [9] = '{8'h20, 8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67, 8'hB0, 8'h78};

    initial begin
        i2.clear = 1'b0; i2.char_valid = 1'b0; i2.char = 8'h00;
        i4.clear = 1'b0; i4.char_valid = 1'b0; i4.char = 8'h00;
        i1.clear = 1'b0; i1.char_valid = 1'b0; i1.char = 8'h00;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_value",  32'(i2.value), 32'h0);
        check("rst_vv",     32'(i2.value_valid), 32'h0);
        check("rst_err",    32'(i2.error), 32'h0);
        check("rst_busy",   32'(i2.busy), 32'h0);
        check("rst_value4", 32'(i4.value), 32'h0);
        step();
        step();
        reset = 1'b0;

        // Basic value
        send2("3");
        check("basic_busy1", 32'(i2.busy), 32'h1);
        check("basic_vv1",   32'(i2.value_valid), 32'h0);
        send2("A");
        check("basic_vv2",   32'(i2.value_valid), 32'h1);
        check("basic_val",   32'(i2.value), 32'h3A);
        check("basic_busy2", 32'(i2.busy), 32'h0);
        step();
        check("basic_vv3",   32'(i2.value_valid), 32'h0);
        check("basic_hold",  32'(i2.value), 32'h3A);

        // Invalid char mid-value
        send2("1");
        send2("G");
        check("inv_err",   32'(i2.error), 32'h1);
        check("inv_vv",    32'(i2.value_valid), 32'h0);
        check("inv_hold",  32'(i2.value), 32'h3A);
        check("inv_busy",  32'(i2.busy), 32'h0);
        step();
        check("inv_err0",  32'(i2.error), 32'h0);
        send2("7");
        send2("7");
        check("inv_vv77",  32'(i2.value_valid), 32'h1);
        check("inv_val77", 32'(i2.value), 32'h77);
        step();
        for (int k = 0; k < 9; k++) begin
            send2(bad[k]);
            check($sformatf("bad_%02h_err", bad[k]), 32'(i2.error), 32'h1);
            check($sformatf("bad_%02h_vv", bad[k]),  32'(i2.value_valid), 32'h0);
            step();
        end
        check("bad_hold", 32'(i2.value), 32'h77);

        // Lowercase with gaps
        send2("f");
        step(); step(); step();
        check("gap_busy", 32'(i2.busy), 32'h1);
        check("gap_vv0",  32'(i2.value_valid), 32'h0);
        send2("0");
        check("gap_vv",   32'(i2.value_valid), 32'h1);
        check("gap_val",  32'(i2.value), 32'hF0);

        // Streaming back to back
        send2("1");
        check("str_vv1",  32'(i2.value_valid), 32'h0);
        send2("2");
        check("str_vv2",  32'(i2.value_valid), 32'h1);
        check("str_val1", 32'(i2.value), 32'h12);
        send2("3");
        check("str_vv3",  32'(i2.value_valid), 32'h0);
        check("str_busy", 32'(i2.busy), 32'h1);
        send2("4");
        check("str_vv4",  32'(i2.value_valid), 32'h1);
        check("str_val2", 32'(i2.value), 32'h34);
        step();

        // Clear aborts the partial value
        send2("5");
        i2.clear = 1'b1;
        step();
        i2.clear = 1'b0;
        check("clr_busy", 32'(i2.busy), 32'h0);
        check("clr_vv",   32'(i2.value_valid), 32'h0);
        check("clr_hold", 32'(i2.value), 32'h34);
        send2("6");
        send2("7");
        check("clr_val",  32'(i2.value), 32'h67);

        // Clear wins over a simultaneous char
        i2.clear = 1'b1;
        send2("9");
        i2.clear = 1'b0;
        check("clrc_busy", 32'(i2.busy), 32'h0);
        send2("A");
        check("clrc_vv0",  32'(i2.value_valid), 32'h0);
        send2("B");
        check("clrc_vv",   32'(i2.value_valid), 32'h1);
        check("clrc_val",  32'(i2.value), 32'hAB);
        step();

        // Four digits
        send4("b");
        check("d4_busy", 32'(i4.busy), 32'h1);
        send4("E");
        send4("e");
        check("d4_vv0",  32'(i4.value_valid), 32'h0);
        send4("F");
        check("d4_vv",   32'(i4.value_valid), 32'h1);
        check("d4_val",  32'(i4.value), 32'hBEEF);
        check("d4_busy0", 32'(i4.busy), 32'h0);

        // Single digit
        send1("7");
        check("d1_vv",   32'(i1.value_valid), 32'h1);
        check("d1_val",  32'(i1.value), 32'h7);
        check("d1_busy", 32'(i1.busy), 32'h0);
        send1("x");
        check("d1_err",  32'(i1.error), 32'h1);
        check("d1_hold", 32'(i1.value), 32'h7);
        send1("c");
        check("d1_val2", 32'(i1.value), 32'hC);
        step();
        check("d1_vv0",  32'(i1.value_valid), 32'h0);

        // Async reset mid-value
        send2("9");
        check("ar_busy1", 32'(i2.busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("ar_value", 32'(i2.value), 32'h0);
        check("ar_busy",  32'(i2.busy), 32'h0);
        check("ar_vv",    32'(i2.value_valid), 32'h0);
        check("ar_err",   32'(i2.error), 32'h0);
        check("ar_val4",  32'(i4.value), 32'h0);
        step();
        reset = 1'b0;
        send2("C");
        send2("D");
        check("ar_vv2",   32'(i2.value_valid), 32'h1);
        check("ar_val2",  32'(i2.value), 32'hCD);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Converts a stream of ASCII hex characters, one per clock, into a binary value of `NumDigits` nibbles, most-significant digit first. It sits behind the UART/command receive path and performs the inverse of the hex-to-ASCII generator used on the transmit path. A completed value is presented with a one-cycle strobe. Any non-hex character raises a one-cycle error and discards the partial value.

## Interface
- `NumDigits`, default 2: hex digits per value; must be ≥ 1. `NumBits = 4*NumDigits`.

- `clk`  in  1  system clock; all registers update on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort of the partial value; has priority over `char_valid`.
- `char_valid`  in  1  `char` is presented this cycle; always accepted, no backpressure.
- `char`  in  8  ASCII character.
- `value`  out  NumBits  last completed value; holds until the next completion.
- `value_valid`  out  1  one-cycle strobe: `value` was just updated.
- `error`  out  1  one-cycle strobe: a non-hex character was received.
- `busy`  out  1  at least one digit of the current value has been accepted.

## Operation
- Hex decode, combinational:
  - "0"–"9" (0x30–0x39) → 0–9.
  - "A"–"F" (0x41–0x46) and "a"–"f" (0x61–0x66) → 10–15.
  - Every other byte is invalid, including space, CR/LF, "x" and bytes ≥ 0x80.
- Internal state:
  - Accumulator `acc[NumBits]`.
  - Digit counter `cnt` with range 0..NumDigits-1, width `max(1,$clog2(NumDigits))`.
- States:
  - IDLE: `cnt` == 0.
  - ACCUM: `cnt` > 0, and `busy` = 1.
- Per-cycle priority, highest first:
  1. `clear`: `cnt` ← 0 and `acc` ← 0. Any char this cycle is dropped, and no strobe is produced.
  2. `char_valid` with an invalid char: `error` ← 1 next cycle, `cnt` ← 0, `acc` ← 0. `value` is unchanged.
  3. `char_valid` with a valid char and `cnt` < NumDigits-1: `acc` ← {acc[NumBits-5:0], nibble} and `cnt` ← `cnt`+1.
  4. `char_valid` with a valid char and `cnt` == NumDigits-1: `value` ← {acc[NumBits-5:0], nibble}, `value_valid` ← 1 next cycle, `cnt` ← 0, `acc` ← 0.
- NumDigits == 1: every valid char completes immediately, `value` ← nibble, and `busy` stays 0. There is no shift of a zero-width slice.
- `value_valid` and `error` are mutually exclusive and never exceed one cycle. When they are not being set they return to 0.
- `char_valid` low cycles between digits leave the state untouched; there is no timeout.
- `value` changes only at a completion, and is zeroed only by `reset`.

## Timing
- Reset, asynchronous: the following are 0 immediately on assertion and held until the first rising edge after deassertion:
  - `value`, `value_valid`, `error`, `busy`
  - internal `acc` and `cnt`
- Reset asserted mid-value discards the partial digits.
- Latency: with the final digit presented in cycle N, `value` and `value_valid` are visible in cycle N+1. An invalid char in cycle N gives `error` in cycle N+1.
- Throughput: one char per cycle, sustained. The first digit of the next value may be presented in the same cycle `value_valid` is high. Back-to-back values complete every NumDigits cycles.
- `busy` is registered; it goes high the cycle after the first digit and low the cycle after completion, error or `clear`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic value (NumDigits=2):** "3","A" in consecutive cycles → `value_valid` = 1 for exactly one cycle, with `value` = 8'h3A. `busy` is high only in the cycle between the two digits.
- **Lowercase with gaps:** "f", then 3 idle cycles, then "0" → `value` = 8'hF0 and one `value_valid` strobe. Extend to NumDigits=4 with "b","E","e","F" → `value` = 16'hBEEF. Then run NumDigits=1 with "7" → `value` = 4'h7, strobe in the next cycle, `busy` never high.
- **Invalid char:**
  - Send "1","G" → `error` strobe the cycle after "G", no `value_valid`, and `value` keeps its prior content (8'h3A).
  - Then send "7","7" → `value` = 8'h77.
  - Repeat with " ", 0x2F, 0x3A, 0x40, 0x47, 0x60, 0x67 and 0xB0; each → `error`.
- **Streaming:** "1","2","3","4" on four consecutive cycles (1–4) → `value_valid` in cycles 3 and 5, carrying 8'h12 then 8'h34. No gap is required.
- **Clear:**
  - "5", then `clear` → `busy` drops with no strobe; then "6","7" → `value` = 8'h67.
  - `clear` together with `char_valid`="9", then "A","B" → 8'hAB, proving the "9" was dropped.
- **Async reset mid-operation:** after "9", assert `reset` between clock edges → all outputs read 0 before the next edge. After deassertion, "C","D" → `value` = 8'hCD, proving the old partial digit was discarded.
